// File: rtl/startup_pkg.sv
// Shared state encoding, default timing constants and width helpers for the
// startup sequencer.
package startup_pkg;

  typedef enum logic [2:0] {
    S_INIT     = 3'd0,
    S_WAIT_ACK = 3'd1,
    S_GAP      = 3'd2,
    S_DONE     = 3'd3,
    S_ERR      = 3'd4
  } state_t;

  localparam int DEF_NUM_STAGES     = 4;
  localparam int DEF_INIT_CYCLES    = 2;
  localparam int DEF_GAP_CYCLES     = 1;
  localparam int DEF_TIMEOUT_CYCLES = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Bits needed to index n items; a single stage still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the values 0..m inclusive.
  function automatic int cnt_width(input int m);
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/seq_down_cnt.sv
// Loadable down-counter that saturates at zero; load wins over decrement.
module seq_down_cnt #(
  parameter int              WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/startup_seq.sv
// Power-up sequencer: raises sticky per-stage enables one at a time after an
// initial delay, optionally waiting for a per-stage ack with a timeout.
module startup_seq
  import startup_pkg::*;
#(
  parameter int                    NUM_STAGES     = DEF_NUM_STAGES,
  parameter int                    INIT_CYCLES    = DEF_INIT_CYCLES,
  parameter int                    GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int                    TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter logic [NUM_STAGES-1:0] ACK_MASK       = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                restart,
  input  logic                                hold,
  input  logic [NUM_STAGES-1:0]               stage_ack,
  output logic [NUM_STAGES-1:0]               stage_en,
  output logic                                busy,
  output logic                                done,
  output logic                                err,
  output logic [idx_width(NUM_STAGES)-1:0]    err_stage
);

  localparam int KW = idx_width(NUM_STAGES);
  localparam int MW = 1 << KW;
  localparam int CW = cnt_width(max3(INIT_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES));

  localparam logic [KW-1:0] LAST        = KW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] INIT_VAL    = CW'(INIT_CYCLES);
  localparam logic [CW-1:0] GAP_VAL     = CW'(GAP_CYCLES);
  localparam logic [CW-1:0] TIMEOUT_VAL = CW'(TIMEOUT_CYCLES);
  // Padded to a power of two so any index value selects a defined bit.
  localparam logic [MW-1:0] ACK_PAD     = MW'(ACK_MASK);

  state_t                r_state;
  logic [KW-1:0]         r_k;
  logic [NUM_STAGES-1:0] r_stage_en;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [KW-1:0]         r_err_stage;

  logic [MW-1:0]         w_ack_pad;
  logic                  w_ack_k;
  logic [KW-1:0]         w_adv_idx;
  logic [NUM_STAGES-1:0] w_adv_onehot;
  state_t                w_adv_state;
  logic                  w_zero;
  logic                  w_load;
  logic [CW-1:0]         w_load_val;
  logic                  w_dec;

  assign w_ack_pad = MW'(stage_ack);
  assign w_ack_k   = w_ack_pad[r_k];

  // Stage about to be enabled when the INIT/GAP countdown expires, and where
  // the FSM goes after enabling it.
  always_comb begin
    w_adv_idx    = (r_state == S_GAP) ? r_k + 1'b1 : '0;
    w_adv_onehot = NUM_STAGES'(1) << w_adv_idx;
    if (ACK_PAD[w_adv_idx]) begin
      w_adv_state = S_WAIT_ACK;
    end else if (w_adv_idx == LAST) begin
      w_adv_state = S_DONE;
    end else begin
      w_adv_state = S_GAP;
    end
  end

  // Counter control mirrors the FSM transitions; hold only pauses INIT/GAP.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = INIT_VAL;
    w_dec      = 1'b0;
    if (restart) begin
      w_load     = 1'b1;
      w_load_val = INIT_VAL;
    end else begin
      case (r_state)
        S_INIT, S_GAP: begin
          if (!hold) begin
            if (w_zero) begin
              w_load     = 1'b1;
              w_load_val = (w_adv_state == S_WAIT_ACK) ? TIMEOUT_VAL : GAP_VAL;
            end else begin
              w_dec = 1'b1;
            end
          end
        end
        S_WAIT_ACK: begin
          if (w_ack_k) begin
            w_load     = 1'b1;
            w_load_val = GAP_VAL;
          end else begin
            w_dec = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  seq_down_cnt #(
    .WIDTH  (CW),
    .RST_VAL(INIT_VAL)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .i_dec     (w_dec),
    .o_zero    (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_INIT;
      r_k         <= '0;
      r_stage_en  <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= '0;
    end else if (restart) begin
      r_state     <= S_INIT;
      r_k         <= '0;
      r_stage_en  <= '0;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_stage <= '0;
    end else begin
      case (r_state)
        S_INIT, S_GAP: begin
          if (w_zero && !hold) begin
            r_stage_en <= r_stage_en | w_adv_onehot;
            r_k        <= w_adv_idx;
            r_state    <= w_adv_state;
            r_busy     <= (w_adv_state != S_DONE);
            r_done     <= (w_adv_state == S_DONE);
          end
        end
        S_WAIT_ACK: begin
          // A late ack on the final timeout cycle still counts as success.
          if (w_ack_k) begin
            if (r_k == LAST) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_GAP;
            end
          end else if (w_zero) begin
            r_state     <= S_ERR;
            r_stage_en  <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b1;
            r_err_stage <= r_k;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign stage_en  = r_stage_en;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign err_stage = r_err_stage;

endmodule

// File: tb/tb_startup_seq.sv
// Scoreboard bench: three sequencers (ACK_MASK 0000, 0010, 0100); expected
// output changes are queued with their edge number and checked by a monitor.
module tb_startup_seq;

  typedef struct {
    int         cyc;
    logic [8:0] val;
  } ev_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  logic       stim_done = 1'b0;

  logic       rst_n_v   [3];
  logic       restart_v [3];
  logic       hold_v    [3];
  logic [3:0] ack_v     [3];
  logic [3:0] en_v      [3];
  logic       busy_v    [3];
  logic       done_v    [3];
  logic       err_v     [3];
  logic [1:0] es_v      [3];

  ev_t        exp_q [3][$];
  int         n_total = 0;
  int         n_bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    startup_seq #(
      .ACK_MASK(gi == 0 ? 4'b0000 : 4'(1 << gi))
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n_v[gi]),
      .restart  (restart_v[gi]),
      .hold     (hold_v[gi]),
      .stage_ack(ack_v[gi]),
      .stage_en (en_v[gi]),
      .busy     (busy_v[gi]),
      .done     (done_v[gi]),
      .err      (err_v[gi]),
      .err_stage(es_v[gi])
    );
  end

  function automatic logic [8:0] pk(input logic [3:0] en, input logic b,
                                    input logic dn, input logic er,
                                    input logic [1:0] es);
    return {en, b, dn, er, es};
  endfunction

  function automatic logic [8:0] run(input logic [3:0] en);
    return pk(en, 1'b1, 1'b0, 1'b0, 2'd0);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int c, input logic [8:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q[d].push_back(e);
  endtask

  // Stimulus: directed scenarios run one DUT at a time.
  initial begin
    int b;
    int r;
    logic [8:0] done_v9;
    logic [8:0] err1_v9;
    done_v9 = pk(4'b1111, 1'b0, 1'b1, 1'b0, 2'd0);
    err1_v9 = pk(4'b0000, 1'b0, 1'b0, 1'b1, 2'd1);
    for (int d = 0; d < 3; d++) begin
      rst_n_v[d]   = 1'b0;
      restart_v[d] = 1'b0;
      hold_v[d]    = 1'b0;
      ack_v[d]     = 4'b0000;
      push(d, 1, run(4'b0000));
    end
    tick(3);

    // DUT0: plain run, then hold during the first gap, then async reset.
    rst_n_v[0] = 1'b1; b = cyc;
    push(0, b + 3, run(4'b0001)); push(0, b + 5, run(4'b0011));
    push(0, b + 7, run(4'b0111)); push(0, b + 9, done_v9);
    tick(11);
    restart_v[0] = 1'b1; r = cyc; tick(1); restart_v[0] = 1'b0;
    push(0, r + 1, run(4'b0000)); push(0, r + 4, run(4'b0001));
    tick(3); hold_v[0] = 1'b1; tick(5); hold_v[0] = 1'b0;
    push(0, r + 11, run(4'b0011)); push(0, r + 13, run(4'b0111));
    push(0, r + 15, done_v9);
    tick(7);
    restart_v[0] = 1'b1; r = cyc; tick(1); restart_v[0] = 1'b0;
    push(0, r + 1, run(4'b0000)); push(0, r + 4, run(4'b0001));
    push(0, r + 6, run(4'b0011));
    tick(6);
    #1 rst_n_v[0] = 1'b0;
    push(0, r + 7, run(4'b0000));
    tick(2); rst_n_v[0] = 1'b1; b = cyc;
    push(0, b + 3, run(4'b0001)); push(0, b + 5, run(4'b0011));
    push(0, b + 7, run(4'b0111)); push(0, b + 9, done_v9);
    tick(10);

    // DUT1: stage 1 acked, then timeout, then restart out of S_ERR.
    rst_n_v[1] = 1'b1; b = cyc;
    push(1, b + 3, run(4'b0001)); push(1, b + 5, run(4'b0011));
    tick(8); ack_v[1] = 4'b0010; tick(1); ack_v[1] = 4'b0000;
    push(1, b + 11, run(4'b0111)); push(1, b + 13, done_v9);
    tick(5);
    restart_v[1] = 1'b1; r = cyc; tick(1); restart_v[1] = 1'b0;
    push(1, r + 1, run(4'b0000)); push(1, r + 4, run(4'b0001));
    push(1, r + 6, run(4'b0011)); push(1, r + 15, err1_v9);
    tick(15);
    restart_v[1] = 1'b1; r = cyc; tick(1); restart_v[1] = 1'b0;
    push(1, r + 1, run(4'b0000)); push(1, r + 4, run(4'b0001));
    push(1, r + 6, run(4'b0011)); push(1, r + 15, err1_v9);
    tick(16);

    // DUT2: restart beats a stage-2 ack; later ack lands on the last timeout cycle.
    rst_n_v[2] = 1'b1; b = cyc;
    push(2, b + 3, run(4'b0001)); push(2, b + 5, run(4'b0011));
    push(2, b + 7, run(4'b0111));
    tick(9); ack_v[2] = 4'b0100; restart_v[2] = 1'b1;
    tick(1); ack_v[2] = 4'b0000; restart_v[2] = 1'b0;
    push(2, b + 10, run(4'b0000)); push(2, b + 13, run(4'b0001));
    push(2, b + 15, run(4'b0011)); push(2, b + 17, run(4'b0111));
    push(2, b + 28, done_v9);
    tick(15); ack_v[2] = 4'b0100; tick(1); ack_v[2] = 4'b0000;
    tick(4);

    tick(3);
    stim_done = 1'b1;
  end

  // Monitor: any change of a DUT's outputs pops and checks one expected event.
  initial begin
    logic [8:0] prev_v [3];
    logic [8:0] smp;
    ev_t        e;
    for (int d = 0; d < 3; d++) prev_v[d] = '1;
    while (!stim_done) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        smp = {en_v[d], busy_v[d], done_v[d], err_v[d], es_v[d]};
        if (smp != prev_v[d]) begin
          prev_v[d] = smp;
          n_total++;
          if (exp_q[d].size() == 0) begin
            n_bad++;
            $display("FAIL dut%0d unexpected_change: cyc=%0d en=%b busy=%b done=%b err=%b err_stage=%0d, required no change",
                     d, cyc, smp[8:5], smp[4], smp[3], smp[2], smp[1:0]);
          end else begin
            e = exp_q[d].pop_front();
            if (e.cyc != cyc || e.val != smp) begin
              n_bad++;
              $display("FAIL dut%0d event: got cyc=%0d en=%b busy=%b done=%b err=%b err_stage=%0d, required cyc=%0d en=%b busy=%b done=%b err=%b err_stage=%0d",
                       d, cyc, smp[8:5], smp[4], smp[3], smp[2], smp[1:0],
                       e.cyc, e.val[8:5], e.val[4], e.val[3], e.val[2], e.val[1:0]);
            end else begin
              $display("ok   dut%0d cyc=%0d en=%b busy=%b done=%b err=%b err_stage=%0d",
                       d, cyc, smp[8:5], smp[4], smp[3], smp[2], smp[1:0]);
            end
          end
        end
      end
    end
    for (int d = 0; d < 3; d++) begin
      n_total++;
      if (exp_q[d].size() != 0) begin
        n_bad++;
        $display("FAIL dut%0d pending_events: got %0d unseen, required 0 (next cyc=%0d)",
                 d, exp_q[d].size(), exp_q[d][0].cyc);
      end
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/startup_seq.md
STARTUP_SEQ -- requirements
Module: startup_seq

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4, number of sequenced enables (legal 1..16).
REQ-002 SHALL have parameter INIT_CYCLES, default 2, idle cycles after reset release before stage 0 enables.
REQ-003 SHALL have parameter GAP_CYCLES, default 1, extra cycles between consecutive stage enables.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 8, cycles a stage may wait for its ack.
REQ-005 SHALL have parameter ACK_MASK, default all-zeros, [NUM_STAGES] bits; bit k set means stage k requires an ack.
REQ-006 SHALL have port clk, input, 1, sole clock; all flops on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port restart, input, 1, synchronous request to rerun the sequence.
REQ-009 SHALL have port hold, input, 1, freezes INIT/GAP countdown while high.
REQ-010 SHALL have port stage_ack, input, NUM_STAGES, per-stage ready acknowledge.
REQ-011 SHALL have port stage_en, output, NUM_STAGES, sticky per-stage enables.
REQ-012 SHALL have port busy, output, 1, high in S_INIT, S_WAIT_ACK and S_GAP.
REQ-013 SHALL have port done, output, 1, high in S_DONE.
REQ-014 SHALL have port err, output, 1, high in S_ERR.
REQ-015 SHALL have port err_stage, output, max(1,clog2(NUM_STAGES)), index of the stage that timed out.

Function
REQ-016 SHALL implement states S_INIT, S_WAIT_ACK, S_GAP, S_DONE, S_ERR, with one down-counter and a stage index k.
REQ-017 S_INIT SHALL decrement the counter each unheld cycle; at counter 0 the next edge sets stage_en[0] and enters S_WAIT_ACK if ACK_MASK[0] else S_GAP.
REQ-018 With no hold, stage_en[0] SHALL rise on the (INIT_CYCLES+1)th rising edge after rst_n deasserts.
REQ-019 On entering S_GAP the counter SHALL load GAP_CYCLES; at 0 (unheld) the next edge sets stage_en[k+1] and increments k.
REQ-020 Without acks, stage_en[k+1] SHALL rise exactly GAP_CYCLES+1 cycles after stage_en[k].
REQ-021 On entering S_WAIT_ACK the counter SHALL load TIMEOUT_CYCLES; stage_ack[k] sampled high advances next edge to S_GAP, or to S_DONE if k is the last stage.
REQ-022 If the counter is 0 and stage_ack[k] is low in S_WAIT_ACK, the next edge SHALL enter S_ERR, clear all stage_en and capture err_stage=k.
REQ-023 An ack arriving in the same cycle the counter reaches 0 SHALL count as success.
REQ-024 After enabling the last stage with its ACK_MASK bit clear, the FSM SHALL enter S_DONE directly, without a gap.
REQ-025 stage_en bits SHALL be monotonic (never cleared) except by reset, restart or error.
REQ-026 hold SHALL NOT freeze the S_WAIT_ACK timeout counter.
REQ-027 restart high SHALL, in any state, on the next edge clear stage_en/err/done, load INIT_CYCLES and enter S_INIT; restart SHALL take priority over a simultaneous ack, timeout or gap expiry.
REQ-028 S_DONE and S_ERR SHALL be terminal until restart or reset.
REQ-029 The counter width SHALL be clog2(max(INIT_CYCLES,GAP_CYCLES,TIMEOUT_CYCLES)+1); with a value of 0 the state SHALL last one cycle.

Reset
REQ-030 rst_n low SHALL asynchronously force S_INIT, counter=INIT_CYCLES, k=0, stage_en=0, done=0, err=0, err_stage=0, busy=1.
REQ-031 Reset asserted mid-sequence SHALL drop all enables immediately, without waiting for a clock edge.

Structure
REQ-032 The state enum typedef and default parameter constants SHALL live in the shared package startup_pkg.
REQ-033 The loadable, hold-able down-counter SHALL be the single sub-module seq_down_cnt.

Verification
REQ-034 Defaults, release rst_n at edge 0 -> stage_en = 0001 @3, 0011 @5, 0111 @7, 1111 @9; done=1 @9.
REQ-035 ACK_MASK=0010, stage_ack[1] high 3 cycles after stage_en[1] rises -> stage_en[2] rises 2 cycles after the ack is sampled.
REQ-036 ACK_MASK=0010, stage_ack held low -> S_ERR 9 cycles after stage_en[1] rises; stage_en=0000, err=1, err_stage=1.
REQ-037 hold high for 5 cycles during S_GAP after stage 0 -> stage_en[1] rises 5 cycles later than in REQ-034.
REQ-038 restart pulsed in the same cycle as the stage 2 ack, and again in S_ERR -> stage_en=0000, FSM in S_INIT, stage_en[0] rises 3 cycles later.
REQ-039 rst_n asserted asynchronously mid-S_GAP with stage_en=0011 -> stage_en=0000 before the next edge, busy=1.
